// File: rtl/fft_feeder_pkg.sv
// Shared types, widths and helpers for the FFT frame feeder.
package fft_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StFlush,
    StDone
  } feeder_state_e;

  localparam int unsigned TDATA_W = 32;
  localparam int unsigned REAL_W  = 16;
  localparam int unsigned IMAG_W  = 16;

  function automatic int unsigned log2_decim(input int unsigned decim);
    return $clog2(decim);
  endfunction

  // Imaginary half is always zero; the FFT consumes a purely real stream.
  function automatic logic [TDATA_W-1:0] pack_tdata(input logic [REAL_W-1:0] re);
    return {{IMAG_W{1'b0}}, re};
  endfunction

endpackage

// File: rtl/boxcar_decim.sv
// Boxcar averager: sums DECIM consecutive samples and strobes their truncated mean.
module boxcar_decim
  import fft_feeder_pkg::*;
#(
  parameter int unsigned DECIM = 8,
  parameter int unsigned ADC_W = 10
) (
  input  logic             fft_clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [ADC_W-1:0] ad_data,
  output logic [ADC_W-1:0] avg,
  output logic             avg_valid
);

  localparam int unsigned LOG2_DECIM = log2_decim(DECIM);
  localparam int unsigned ACC_W      = ADC_W + LOG2_DECIM;
  localparam int unsigned CNT_W      = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q;
  logic             last_tap;

  always_comb begin
    last_tap  = (cnt_q == CNT_W'(DECIM - 1));
    sum       = acc_q + ACC_W'(ad_data);
    avg       = ADC_W'(sum >> LOG2_DECIM);
    avg_valid = enable && last_tap;
  end

  always_ff @(posedge fft_clk) begin
    if (rst || clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (enable) begin
      if (last_tap) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Captures ADC samples, decimates by averaging and streams one FRAME_LEN-word
// frame into an AXI-Stream FFT core per start request.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4096,
  parameter int unsigned DECIM     = 8,
  parameter int unsigned ADC_W     = 10
) (
  input  logic               fft_clk,
  input  logic               rst,
  input  logic [ADC_W-1:0]   ad_data,
  input  logic               start,
  output logic [TDATA_W-1:0] m_axis_data_tdata,
  output logic               m_axis_data_tvalid,
  input  logic               m_axis_data_tready,
  output logic               m_axis_data_tlast,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow
);

  localparam int unsigned LOAD_W = $clog2(FRAME_LEN + 1);

  feeder_state_e      state_q;
  logic [LOAD_W-1:0]  load_cnt_q;
  logic [TDATA_W-1:0] tdata_q;
  logic               tvalid_q;
  logic               tlast_q;
  logic               overflow_q;

  logic               capture;
  logic               clear;
  logic               avg_valid;
  logic [ADC_W-1:0]   avg;
  logic               handshake;
  logic               can_load;
  logic               last_load;

  always_comb begin
    capture   = (state_q == StCapture);
    clear     = (state_q == StIdle) && start;
    handshake = tvalid_q && m_axis_data_tready;
    // A word being accepted this cycle frees the slot for the new average.
    can_load  = !tvalid_q || m_axis_data_tready;
    last_load = (load_cnt_q == LOAD_W'(FRAME_LEN - 1));
  end

  boxcar_decim #(
    .DECIM (DECIM),
    .ADC_W (ADC_W)
  ) u_boxcar (
    .fft_clk   (fft_clk),
    .rst       (rst),
    .clear     (clear),
    .enable    (capture),
    .ad_data   (ad_data),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

  always_ff @(posedge fft_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      load_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StCapture;
            load_cnt_q <= '0;
            overflow_q <= 1'b0;
          end
        end
        StCapture: begin
          if (handshake) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
          if (avg_valid) begin
            if (can_load) begin
              tdata_q    <= pack_tdata(REAL_W'(avg));
              tvalid_q   <= 1'b1;
              tlast_q    <= last_load;
              load_cnt_q <= load_cnt_q + LOAD_W'(1);
              if (last_load) begin
                state_q <= StFlush;
              end
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        StFlush: begin
          if (handshake) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    m_axis_data_tdata  = tdata_q;
    m_axis_data_tvalid = tvalid_q;
    m_axis_data_tlast  = tlast_q;
    busy               = (state_q != StIdle);
    frame_done         = (state_q == StDone);
    overflow           = overflow_q;
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench: a frame-level reference model queues expected words, a
// negedge monitor checks every handshake and hold behaviour under stall.
module tb_fft_frame_feeder;

  localparam int unsigned FL = 16;
  localparam int unsigned DC = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: FRAME_LEN=16, DECIM=4
  logic        rst, start, tready;
  logic [9:0]  ad_data;
  logic [31:0] tdata;
  logic        tvalid, tlast, busy, frame_done, overflow;

  // Edge-case DUT: FRAME_LEN=4, DECIM=1
  logic        rst1, start1, tready1;
  logic [9:0]  ad1;
  logic [31:0] tdata1;
  logic        tvalid1, tlast1, busy1, fd1, ovf1;

  fft_frame_feeder #(.FRAME_LEN(FL), .DECIM(DC), .ADC_W(10)) dut (
    .fft_clk            (clk),
    .rst                (rst),
    .ad_data            (ad_data),
    .start              (start),
    .m_axis_data_tdata  (tdata),
    .m_axis_data_tvalid (tvalid),
    .m_axis_data_tready (tready),
    .m_axis_data_tlast  (tlast),
    .busy               (busy),
    .frame_done         (frame_done),
    .overflow           (overflow)
  );

  fft_frame_feeder #(.FRAME_LEN(4), .DECIM(1), .ADC_W(10)) dut1 (
    .fft_clk            (clk),
    .rst                (rst1),
    .ad_data            (ad1),
    .start              (start1),
    .m_axis_data_tdata  (tdata1),
    .m_axis_data_tvalid (tvalid1),
    .m_axis_data_tready (tready1),
    .m_axis_data_tlast  (tlast1),
    .busy               (busy1),
    .frame_done         (fd1),
    .overflow           (ovf1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: block means of DECIM samples, one-word output slot.
  logic [32:0] exp_q[$];
  bit m_cap, m_flush, m_done, m_slot, m_ovf;
  int m_sum, m_n, m_loads, m_fd_exp;

  function automatic void model_cycle(input int ad, input bit rdy, input bit st);
    bit hs;
    bit load;
    int avg;
    hs   = m_slot && rdy;
    load = 1'b0;
    if (m_cap) begin
      m_sum += ad;
      m_n++;
      if (m_n == DC) begin
        avg   = m_sum / DC;
        m_sum = 0;
        m_n   = 0;
        if (!m_slot || rdy) begin
          m_loads++;
          load = 1'b1;
          exp_q.push_back({(m_loads == FL), 16'h0000, 16'(avg)});
          if (m_loads == FL) begin
            m_cap   = 1'b0;
            m_flush = 1'b1;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end else if (m_flush) begin
      if (hs) begin
        m_flush = 1'b0;
        m_done  = 1'b1;
        m_fd_exp++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (st) begin
      m_cap   = 1'b1;
      m_sum   = 0;
      m_n     = 0;
      m_loads = 0;
      m_ovf   = 1'b0;
    end
    if (load) m_slot = 1'b1;
    else if (hs) m_slot = 1'b0;
  endfunction

  function automatic void model_reset();
    m_cap   = 1'b0;
    m_flush = 1'b0;
    m_done  = 1'b0;
    m_slot  = 1'b0;
    m_ovf   = 1'b0;
    m_sum   = 0;
    m_n     = 0;
    m_loads = 0;
    exp_q.delete();
  endfunction

  task automatic step(input int ad, input bit rdy, input bit st);
    ad_data = 10'(ad);
    tready  = rdy;
    start   = st;
    model_cycle(ad, rdy, st);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_rst();
    rst    = 1'b1;
    tready = 1'b0;
    start  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
  endtask

  // Monitor
  int          mon_words = 0;
  int          fd_seen   = 0;
  bit          prev_stall = 1'b0;
  bit          prev_rst   = 1'b1;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [32:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && !prev_rst) begin
        check("hold_tvalid", 64'(tvalid), 64'd1);
        check("hold_tdata", 64'(tdata), 64'(prev_data));
        check("hold_tlast", 64'(tlast), 64'(prev_last));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("tdata", 64'(tdata), 64'(mon_e[31:0]));
          check("tlast", 64'(tlast), 64'(mon_e[32]));
        end
        mon_words++;
      end
      if (frame_done) fd_seen++;
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    prev_rst   = rst;
  end

  // mode 0: const 100; 1: ramp + ignored start; 2: back-pressure; 3: random
  task automatic run_frame(input int mode);
    int start_cyc, lat, fd0, ad;
    bit rdy, st;
    mon_words = 0;
    fd0       = fd_seen;
    lat       = -1;
    start_cyc = cyc;
    step(0, 1'b1, 1'b1);
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      st = 1'b0;
      case (mode)
        0: begin ad = 100; rdy = 1'b1; end
        1: begin ad = k; rdy = 1'b1; st = (k == 2); end
        2: begin ad = int'($urandom_range(0, 1023)); rdy = !(k >= 20 && k < 30); end
        default: begin ad = int'($urandom_range(0, 1023)); rdy = ($urandom_range(0, 3) != 0); end
      endcase
      step(ad, rdy, st);
      if (lat < 0 && tvalid) lat = cyc - start_cyc;
    end
    check("frame_ends", 64'(busy), 64'd0);
    check("first_tvalid_latency", 64'(lat), 64'(DC + 1));
    check("words_per_frame", 64'(mon_words), 64'(FL));
    check("frame_done_count", 64'(fd_seen - fd0), 64'd1);
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    if (mode == 0 || mode == 1) check("overflow_clean", 64'(overflow), 64'd0);
    if (mode == 2) check("overflow_backpressure", 64'(overflow), 64'd1);
    step(0, 1'b1, 1'b0);
  endtask

  initial begin
    int fd0, start_cyc;
    rst = 1'b1; start = 1'b0; tready = 1'b0; ad_data = '0;
    rst1 = 1'b1; start1 = 1'b0; tready1 = 1'b1; ad1 = 10'd1023;
    model_reset();
    m_fd_exp = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst1_tvalid", 64'(tvalid1), 64'd0);
    rst = 1'b0;
    rst1 = 1'b0;
    step(0, 1'b1, 1'b0);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    check("overflow_sticky_idle", 64'(overflow), 64'd1);
    run_frame(3);
    run_frame(3);

    // Reset mid-frame after the 7th accepted word.
    mon_words = 0;
    fd0 = fd_seen;
    step(0, 1'b1, 1'b1);
    for (int k = 0; k < 200; k++) begin
      if (mon_words >= 7) break;
      step(int'($urandom_range(0, 1023)), 1'b1, 1'b0);
    end
    check("reached_word7", 64'(mon_words), 64'd7);
    step_rst();
    check("midrst_tvalid", 64'(tvalid), 64'd0);
    check("midrst_tlast", 64'(tlast), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 6; k++) step(5, 1'b1, 1'b0);
    check("midrst_no_frame_done", 64'(fd_seen - fd0), 64'd0);
    run_frame(0);

    // DECIM=1 edge case on the second instance.
    start_cyc = cyc;
    start1 = 1'b1;
    step(0, 1'b1, 1'b0);
    start1 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check("d1_tvalid", 64'(tvalid1), 64'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check("d1_tdata", 64'(tdata1), 64'd1023);
        check("d1_tlast", 64'(tlast1), 64'(k == 5));
      end
      check("d1_frame_done", 64'(fd1), 64'(k == 6));
      step(0, 1'b1, 1'b0);
    end
    check("d1_elapsed", 64'(cyc - start_cyc), 64'd8);
    check("d1_overflow", 64'(ovf1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_feeder.md
FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 4096, giving the number of averaged samples per FFT frame.
REQ-002 The block SHALL have parameter DECIM, default 8, giving the averaging/decimation factor; it is a power of two, 1..64.
REQ-003 The block SHALL have parameter ADC_W, default 10, giving the ADC sample width.
REQ-004 The block SHALL have these ports:
- fft_clk  in  1  sole clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- ad_data  in  ADC_W  unsigned ADC sample, valid every cycle.
- start  in  1  single-cycle frame request, already synchronised to fft_clk.
- m_axis_data_tdata  out  32  {16'h0000 imag, 16-bit zero-extended real}.
- m_axis_data_tvalid  out  1  data valid.
- m_axis_data_tready  in  1  FFT ready.
- m_axis_data_tlast  out  1  last sample of frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the final handshake.
- overflow  out  1  sticky; an averaged sample was dropped in this frame.

Function
REQ-005 The block SHALL implement states IDLE, CAPTURE, FLUSH and DONE.
REQ-006 In IDLE with start=1, the block SHALL enter CAPTURE on the next cycle, clear the accumulator, decimation counter, load counter and overflow.
REQ-007 In CAPTURE, the block SHALL add ad_data to an accumulator of width ADC_W+log2(DECIM) every cycle, and step a decimation counter from 0 to DECIM-1.
REQ-008 When the decimation counter reaches DECIM-1, the block SHALL form avg = (acc + ad_data) >> log2(DECIM), truncating, and restart the accumulator at 0.
REQ-009 If the output register is empty, or is handshaking in the same cycle, avg SHALL load into the output register; tvalid SHALL be 1 on the following cycle.
REQ-010 If the output register holds an unaccepted word (tvalid=1, tready=0) when avg forms, avg SHALL be dropped and overflow SHALL be set; a dropped avg SHALL NOT count toward FRAME_LEN.
REQ-011 The latency from start to the first tvalid SHALL be DECIM+1 cycles (start at cycle t gives tvalid at t+DECIM+1).
REQ-012 tdata, tvalid and tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-013 tlast SHALL be 1 exactly on the FRAME_LEN-th loaded word.
REQ-014 After the FRAME_LEN-th load, the block SHALL enter FLUSH, stop accumulating, and wait for that word's handshake.
REQ-015 The handshake of the tlast word SHALL move the block to DONE. DONE SHALL assert frame_done for one cycle and return to IDLE.
REQ-016 busy SHALL be 1 in CAPTURE, FLUSH and DONE, and 0 in IDLE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 overflow SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-019 With DECIM=1, every cycle's ad_data SHALL be an output candidate unchanged.

Reset
REQ-020 On rst=1 at a clock edge, the block SHALL enter IDLE, clear all counters and the accumulator, and drive tvalid=0, tlast=0, tdata=0, busy=0, frame_done=0 and overflow=0.
REQ-021 rst asserted mid-frame SHALL drop tvalid on the next edge with no tlast or frame_done emitted; rst SHALL take priority over start.

Structure
REQ-022 The state enumeration, the LOG2_DECIM derivation and the tdata packing widths SHALL live in shared package fft_feeder_pkg.
REQ-023 The averaging datapath (accumulator, decimation counter, avg strobe) SHALL be a sub-module boxcar_decim; the FSM, output register and counters SHALL stay in fft_frame_feeder.

Verification
REQ-024 The bench SHALL cover the following scenarios, using FRAME_LEN=16 and DECIM=4:
- Basic frame: ad_data constant 100, tready=1, start pulse -> first tvalid 5 cycles after start; 16 words of real 100; tlast on word 16 only; frame_done 1 cycle later; overflow=0.
- Averaging: ad_data ramp 0,1,2,3,... -> words 1, 5, 9, ... (truncated means); imag field = 0.
- Back-pressure: tready=0 for 10 cycles mid-frame -> tdata held stable; 2 averages dropped; overflow=1; still exactly 16 words with tlast on the 16th.
- Start ignored: second start pulse during CAPTURE -> no effect; a single frame_done.
- Reset: rst mid-frame at word 7 -> tvalid=0 next cycle; busy=0; no frame_done; a later start yields a full clean frame.
- Edge case: DECIM=1, FRAME_LEN=4, ad_data=1023 -> 4 words of 1023; first tvalid 2 cycles after start.
